// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, load-data extraction and result
// selection feeding the register-file write port. It also keeps a
// retired-instruction counter.
// Every output is a function of registered state only, so the outputs are
// stable for the whole cycle and can also act as the WB forwarding source.
module wb_stage #(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic         flush,
   input  logic         memValid,
   input  logic         memRegWrite,
   input  logic [4:0]   memRd,
   input  logic [1:0]   memResSel,
   input  logic [2:0]   memFunct3,
   input  logic [N-1:0] memAluRes,
   input  logic [N-1:0] memLoadData,
   input  logic [N-1:0] memPcPlus4,
   input  logic [N-1:0] memImm,
   output logic         regWriteS,
   output logic [4:0]   writeReg,
   output logic [N-1:0] writeData,
   output logic         wbValid,
   output logic [31:0]  retireCount
);

   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned CNT_W     = 32;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned HALF_W    = 16;

   // Result-source encodings
   localparam logic [1:0] RES_ALU  = 2'b00;
   localparam logic [1:0] RES_LOAD = 2'b01;
   localparam logic [1:0] RES_PC4  = 2'b10;
   localparam logic [1:0] RES_IMM  = 2'b11;

   // Load funct3 encodings; any other code behaves as lw
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Pipeline register payload
   typedef struct packed {
      logic                 valid;
      logic                 reg_write;
      logic [REG_IDX_W-1:0] rd;
      logic [1:0]           res_sel;
      logic [2:0]           funct3;
      logic [1:0]           off;
      logic [N-1:0]         alu_res;
      logic [N-1:0]         load_data;
      logic [N-1:0]         pc_plus4;
      logic [N-1:0]         imm;
   } wb_reg_t;

   wb_reg_t            wb_q, wb_d;
   logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;

   logic [BYTE_W-1:0]  byte_sel;
   logic [HALF_W-1:0]  half_sel;
   logic [N-1:0]       load_ext;
   logic [N-1:0]       result;

   // Next-state: flush bubbles, stall holds, otherwise capture MEM stage
   always_comb begin
      wb_d         = wb_q;
      retire_cnt_d = retire_cnt_q;
      if (flush) begin
         wb_d.valid     = 1'b0;
         wb_d.reg_write = 1'b0;
      end else if (!stall) begin
         wb_d.valid     = memValid;
         wb_d.reg_write = memRegWrite;
         wb_d.rd        = memRd;
         wb_d.res_sel   = memResSel;
         wb_d.funct3    = memFunct3;
         wb_d.off       = memAluRes[1:0];
         wb_d.alu_res   = memAluRes;
         wb_d.load_data = memLoadData;
         wb_d.pc_plus4  = memPcPlus4;
         wb_d.imm       = memImm;
         if (memValid) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
         end
      end
   end

   // State register with synchronous reset taking priority over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_q         <= '0;
         retire_cnt_q <= '0;
      end else begin
         wb_q         <= wb_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   // Byte lane chosen by the low address bits
   always_comb begin
      byte_sel = wb_q.load_data[7:0];
      unique case (wb_q.off)
         2'd0: byte_sel = wb_q.load_data[7:0];
         2'd1: byte_sel = wb_q.load_data[15:8];
         2'd2: byte_sel = wb_q.load_data[23:16];
         2'd3: byte_sel = wb_q.load_data[31:24];
         default: byte_sel = wb_q.load_data[7:0];
      endcase
   end

   // Halfword lane; off[0] is ignored
   always_comb begin
      half_sel = wb_q.off[1] ? wb_q.load_data[31:16] : wb_q.load_data[15:0];
   end

   // Sign/zero extension by load type
   always_comb begin
      load_ext = wb_q.load_data;
      case (wb_q.funct3)
         F3_LB:   load_ext = {{(N-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
         F3_LH:   load_ext = {{(N-HALF_W){half_sel[HALF_W-1]}}, half_sel};
         F3_LBU:  load_ext = {{(N-BYTE_W){1'b0}}, byte_sel};
         F3_LHU:  load_ext = {{(N-HALF_W){1'b0}}, half_sel};
         default: load_ext = wb_q.load_data;
      endcase
   end

   // Writeback result selection
   always_comb begin
      result = wb_q.alu_res;
      unique case (wb_q.res_sel)
         RES_ALU:  result = wb_q.alu_res;
         RES_LOAD: result = load_ext;
         RES_PC4:  result = wb_q.pc_plus4;
         RES_IMM:  result = wb_q.imm;
         default:  result = wb_q.alu_res;
      endcase
   end

   // Register-file port; writes to x0 are suppressed but still retire
   always_comb begin
      regWriteS   = wb_q.valid & wb_q.reg_write & (wb_q.rd != REG_IDX_W'(0));
      writeReg    = wb_q.rd;
      writeData   = result;
      wbValid     = wb_q.valid;
      retireCount = retire_cnt_q;
   end

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed vector table plus hand-written multi-cycle sequences.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic        memValid, memRegWrite;
   logic [4:0]  memRd;
   logic [1:0]  memResSel;
   logic [2:0]  memFunct3;
   logic [31:0] memAluRes, memLoadData, memPcPlus4, memImm;
   logic        regWriteS, wbValid;
   logic [4:0]  writeReg;
   logic [31:0] writeData, retireCount;

   int checks   = 0;
   int failures = 0;

   wb_stage #(.N(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .memValid(memValid), .memRegWrite(memRegWrite), .memRd(memRd),
      .memResSel(memResSel), .memFunct3(memFunct3), .memAluRes(memAluRes),
      .memLoadData(memLoadData), .memPcPlus4(memPcPlus4), .memImm(memImm),
      .regWriteS(regWriteS), .writeReg(writeReg), .writeData(writeData),
      .wbValid(wbValid), .retireCount(retireCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic        rw;
      logic [4:0]  rd;
      logic [1:0]  sel;
      logic [2:0]  f3;
      logic [31:0] alu;
      logic [31:0] ld;
      logic [31:0] pc;
      logic [31:0] imm;
      logic        exp_we;
      logic [31:0] exp_data;
      logic        exp_valid;
      logic [31:0] exp_retire;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic valid, logic rw, logic [4:0] rd, logic [1:0] sel,
                               logic [2:0] f3, logic [31:0] alu, logic [31:0] ld,
                               logic [31:0] pc, logic [31:0] imm, logic exp_we,
                               logic [31:0] exp_data, logic exp_valid, logic [31:0] exp_retire);
      vec_t v;
      v.valid = valid; v.rw = rw; v.rd = rd; v.sel = sel; v.f3 = f3;
      v.alu = alu; v.ld = ld; v.pc = pc; v.imm = imm;
      v.exp_we = exp_we; v.exp_data = exp_data; v.exp_valid = exp_valid;
      v.exp_retire = exp_retire;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic valid, input logic rw, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] ld, input logic [31:0] pc, input logic [31:0] imm);
      memValid = valid; memRegWrite = rw; memRd = rd; memResSel = sel; memFunct3 = f3;
      memAluRes = alu; memLoadData = ld; memPcPlus4 = pc; memImm = imm;
   endtask

   // Advance one rising edge and settle before sampling
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic we, input logic [4:0] rd,
                            input logic [31:0] data, input logic valid, input logic [31:0] ret);
      check({tag, "_we"},     32'(regWriteS), 32'(we));
      check({tag, "_rd"},     32'(writeReg),  32'(rd));
      check({tag, "_data"},   writeData,      data);
      check({tag, "_valid"},  32'(wbValid),   32'(valid));
      check({tag, "_retire"}, retireCount,    ret);
   endtask

   localparam logic [31:0] LD = 32'h80FF_7F01;

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b010, 32'h1111_1111, LD, 32'h4, 32'h0);

      // Reset held for two edges while MEM presents a valid writing instruction
      for (int i = 0; i < 2; i++) begin
         step();
         check_all($sformatf("reset%0d", i), 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
      end
      rst = 1'b0;

      // valid rw rd sel f3 alu ld pc imm | we data valid retire
      vecs.push_back(mk(1,1,5'd5,2'b00,3'b000,32'h1234_5678,LD,32'h0,32'h0, 1,32'h1234_5678,1,32'd1));
      vecs.push_back(mk(1,1,5'd0,2'b00,3'b000,32'h1234_5678,LD,32'h0,32'h0, 0,32'h1234_5678,1,32'd2));
      vecs.push_back(mk(1,1,5'd3,2'b01,3'b000,32'h1000_0002,LD,32'h0,32'h0, 1,32'hFFFF_FFFF,1,32'd3));
      vecs.push_back(mk(1,1,5'd3,2'b01,3'b100,32'h1000_0003,LD,32'h0,32'h0, 1,32'h0000_0080,1,32'd4));
      vecs.push_back(mk(1,1,5'd3,2'b01,3'b001,32'h1000_0002,LD,32'h0,32'h0, 1,32'hFFFF_80FF,1,32'd5));
      vecs.push_back(mk(1,1,5'd3,2'b01,3'b101,32'h1000_0000,LD,32'h0,32'h0, 1,32'h0000_7F01,1,32'd6));
      vecs.push_back(mk(1,1,5'd3,2'b01,3'b010,32'h1000_0001,LD,32'h0,32'h0, 1,32'h80FF_7F01,1,32'd7));
      vecs.push_back(mk(1,1,5'd3,2'b01,3'b111,32'h1000_0000,LD,32'h0,32'h0, 1,32'h80FF_7F01,1,32'd8));
      vecs.push_back(mk(1,1,5'd3,2'b01,3'b001,32'h1000_0003,LD,32'h0,32'h0, 1,32'hFFFF_80FF,1,32'd9));
      vecs.push_back(mk(1,1,5'd3,2'b01,3'b101,32'h1000_0001,LD,32'h0,32'h0, 1,32'h0000_7F01,1,32'd10));
      vecs.push_back(mk(1,1,5'd3,2'b01,3'b000,32'h1000_0001,LD,32'h0,32'h0, 1,32'h0000_007F,1,32'd11));
      vecs.push_back(mk(1,1,5'd3,2'b01,3'b000,32'h1000_0000,LD,32'h0,32'h0, 1,32'h0000_0001,1,32'd12));
      vecs.push_back(mk(1,1,5'd4,2'b10,3'b000,32'h0,LD,32'h0000_0104,32'h0, 1,32'h0000_0104,1,32'd13));
      vecs.push_back(mk(1,1,5'd4,2'b11,3'b000,32'h0,LD,32'h0,32'hABCD_E000, 1,32'hABCD_E000,1,32'd14));
      vecs.push_back(mk(0,1,5'd4,2'b00,3'b000,32'h55,LD,32'h0,32'h0,        0,32'h0000_0055,0,32'd14));
      vecs.push_back(mk(1,0,5'd6,2'b00,3'b000,32'h66,LD,32'h0,32'h0,        0,32'h0000_0066,1,32'd15));
      vecs.push_back(mk(1,1,5'd6,2'b01,3'b011,32'h1000_0002,LD,32'h0,32'h0, 1,32'h80FF_7F01,1,32'd16));
      vecs.push_back(mk(1,1,5'd6,2'b01,3'b110,32'h1000_0003,LD,32'h0,32'h0, 1,32'h80FF_7F01,1,32'd17));

      foreach (vecs[i]) begin
         drive(vecs[i].valid, vecs[i].rw, vecs[i].rd, vecs[i].sel, vecs[i].f3,
               vecs[i].alu, vecs[i].ld, vecs[i].pc, vecs[i].imm);
         step();
         check_all($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].rd,
                   vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_retire);
      end

      // Stall: rd=7/0xA captured, then held for three cycles while MEM moves on
      drive(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 32'hA, LD, 32'h0, 32'h0);
      step();
      check_all("stall_load", 1'b1, 5'd7, 32'hA, 1'b1, 32'd18);
      stall = 1'b1;
      drive(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 32'hB, LD, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_all($sformatf("stall_hold%0d", i), 1'b1, 5'd7, 32'hA, 1'b1, 32'd18);
      end
      stall = 1'b0;
      step();
      check_all("stall_release", 1'b1, 5'd9, 32'hB, 1'b1, 32'd19);

      // Flush overrides stall: bubble, no retire
      stall = 1'b1; flush = 1'b1;
      drive(1'b1, 1'b1, 5'd10, 2'b00, 3'b000, 32'hC, LD, 32'h0, 32'h0);
      step();
      check("flush_valid",  32'(wbValid),   32'd0);
      check("flush_we",     32'(regWriteS), 32'd0);
      check("flush_retire", retireCount,    32'd19);
      stall = 1'b0;
      step();
      check("flush_only_valid",  32'(wbValid), 32'd0);
      check("flush_only_retire", retireCount,  32'd19);
      flush = 1'b0;

      // Back-to-back writes to the same rd: each cycle shows its own data
      drive(1'b1, 1'b1, 5'd8, 2'b00, 3'b000, 32'h1, LD, 32'h0, 32'h0);
      step();
      check_all("b2b_first", 1'b1, 5'd8, 32'h1, 1'b1, 32'd20);
      drive(1'b1, 1'b1, 5'd8, 2'b00, 3'b000, 32'h2, LD, 32'h0, 32'h0);
      step();
      check_all("b2b_second", 1'b1, 5'd8, 32'h2, 1'b1, 32'd21);

      // Reset during stall wins
      stall = 1'b1; rst = 1'b1;
      step();
      check_all("rst_stall", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
      stall = 1'b0; flush = 1'b1;
      step();
      check_all("rst_flush", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
      rst = 1'b0; flush = 1'b0;

      // Counter wrap from all-ones
      @(negedge clk);
      force dut.retire_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt_q;
      drive(1'b1, 1'b1, 5'd11, 2'b00, 3'b000, 32'hD, LD, 32'h0, 32'h0);
      step();
      check("wrap_retire", retireCount, 32'd0);
      check("wrap_data",   writeData,   32'hD);
      step();
      check("wrap_next",   retireCount, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
